led_line_driver: RTL and testbench

LED_LINE_DRIVER -- requirements
Module: led_line_driver

---
 rtl/led_line_driver.sv | 152 +++++++++++++++
 tb/tb_led_line_driver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/led_line_driver.sv
// Multi-channel serial LED line driver: fetches one pixel word per LED, serialises all
// channels in lock-step as fixed-period pulses (T1H/T0H high), then holds a reset latch.
module led_line_driver #(
  parameter int CH         = 4,
  parameter int LEDS       = 60,
  parameter int DATA_WIDTH = 24,
  parameter int T0H        = 20,
  parameter int T1H        = 40,
  parameter int TBIT       = 63,
  parameter int TRESET     = 3000,
  localparam int IW        = (LEDS > 1) ? $clog2(LEDS) : 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic [CH-1:0]              CH_EN,
  output logic                       PIX_REQ,
  output logic [IW-1:0]              PIX_IDX,
  input  logic [CH*DATA_WIDTH-1:0]   PIX_DATA,
  output logic [CH-1:0]              LED_SIG,
  output logic                       BUSY,
  output logic                       DONE
);

  localparam int PW = $clog2(TBIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int LW = (TRESET > 1) ? $clog2(TRESET) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_LATCH   = 3'd4;

  localparam logic [PW-1:0] P_LAST = PW'(TBIT - 1);
  localparam logic [PW-1:0] P_T0H  = PW'(T0H);
  localparam logic [PW-1:0] P_T1H  = PW'(T1H);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] I_LAST = IW'(LEDS - 1);
  localparam logic [LW-1:0] L_LAST = LW'(TRESET - 1);

  logic [2:0]               state, state_n;
  logic [CH-1:0]            en, en_n;
  logic [IW-1:0]            idx, idx_n;
  logic [CH*DATA_WIDTH-1:0] shift, shift_n;
  logic [PW-1:0]            period, period_n;
  logic [BW-1:0]            bit_cnt, bit_n;
  logic [LW-1:0]            lat_cnt, lat_n;
  logic [CH-1:0]            led, led_n;
  logic                     busy, pix_req, done, done_n;

  always_comb begin
    state_n  = state;
    en_n     = en;
    idx_n    = idx;
    shift_n  = shift;
    period_n = period;
    bit_n    = bit_cnt;
    lat_n    = lat_cnt;
    done_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          state_n = S_FETCH;
          en_n    = CH_EN;
          idx_n   = '0;
        end
      end
      S_FETCH: state_n = S_CAPTURE;
      S_CAPTURE: begin
        state_n  = S_SEND;
        shift_n  = PIX_DATA;
        period_n = '0;
        bit_n    = '0;
      end
      S_SEND: begin
        if (period == P_LAST) begin
          period_n = '0;
          // Shift each channel on its own so channel MSBs never cross lanes.
          for (int c = 0; c < CH; c++)
            shift_n[c*DATA_WIDTH +: DATA_WIDTH] = {shift[c*DATA_WIDTH +: DATA_WIDTH-1], 1'b0};
          if (bit_cnt == B_LAST) begin
            bit_n = '0;
            if (idx == I_LAST) begin
              state_n = S_LATCH;
              lat_n   = '0;
            end else begin
              state_n = S_FETCH;
              idx_n   = idx + IW'(1);
            end
          end else begin
            bit_n = bit_cnt + BW'(1);
          end
        end else begin
          period_n = period + PW'(1);
        end
      end
      S_LATCH: begin
        if (lat_cnt == L_LAST) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          lat_n = lat_cnt + LW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Line levels are computed from next-cycle state so LED_SIG comes straight off a flop.
    led_n = '0;
    if (state_n == S_SEND) begin
      for (int c = 0; c < CH; c++)
        led_n[c] = en_n[c] &
                   (period_n < (shift_n[c*DATA_WIDTH + DATA_WIDTH-1] ? P_T1H : P_T0H));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      en      <= '0;
      idx     <= '0;
      shift   <= '0;
      period  <= '0;
      bit_cnt <= '0;
      lat_cnt <= '0;
      led     <= '0;
      busy    <= 1'b0;
      pix_req <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      en      <= en_n;
      idx     <= idx_n;
      shift   <= shift_n;
      period  <= period_n;
      bit_cnt <= bit_n;
      lat_cnt <= lat_n;
      led     <= led_n;
      busy    <= (state_n != S_IDLE);
      pix_req <= (state_n == S_FETCH);
      done    <= done_n;
    end
  end

  assign PIX_REQ = pix_req;
  assign PIX_IDX = idx;
  assign LED_SIG = led;
  assign BUSY    = busy;
  assign DONE    = done;

endmodule

// File: tb/tb_led_line_driver.sv
// Directed bench: single-LED waveform timing on a 1-channel instance, then masking,
// fetch spacing, START handling and mid-frame reset on a 4-channel, 3-LED instance.
module tb_led_line_driver;

  logic        CLK;
  logic        RST1, START1, PIX_REQ1, BUSY1, DONE1;
  logic [0:0]  CH_EN1, PIX_IDX1, LED_SIG1;
  logic [23:0] PIX_DATA1;

  logic        RST4, START4, PIX_REQ4, BUSY4, DONE4;
  logic [3:0]  CH_EN4, LED_SIG4;
  logic [1:0]  PIX_IDX4;
  logic [95:0] PIX_DATA4;

  int n_checks = 0;
  int n_fail   = 0;

  logic       tr1 [0:4600];
  logic [3:0] tr4 [0:7600];

  led_line_driver #(.CH(1), .LEDS(1)) dut1 (
    .CLK(CLK), .RST(RST1), .START(START1), .CH_EN(CH_EN1), .PIX_REQ(PIX_REQ1),
    .PIX_IDX(PIX_IDX1), .PIX_DATA(PIX_DATA1), .LED_SIG(LED_SIG1), .BUSY(BUSY1), .DONE(DONE1)
  );

  led_line_driver #(.CH(4), .LEDS(3)) dut4 (
    .CLK(CLK), .RST(RST4), .START(START4), .CH_EN(CH_EN4), .PIX_REQ(PIX_REQ4),
    .PIX_IDX(PIX_IDX4), .PIX_DATA(PIX_DATA4), .LED_SIG(LED_SIG4), .BUSY(BUSY4), .DONE(DONE4)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  // Pixel words per LED index, channel 0 in the low 24 bits.
  function automatic logic [95:0] row(input logic [1:0] i);
    case (i)
      2'd0:    row = {24'hFFFFFF, 24'h123456, 24'hFFFFFF, 24'hA50F3C};
      2'd1:    row = {24'h555555, 24'hC3007E, 24'hAAAAAA, 24'h00FF81};
      2'd2:    row = {24'h0FF00F, 24'h7FFFFE, 24'hFF00FF, 24'h800001};
      default: row = {96{1'b1}};
    endcase
  endfunction

  // Pixel memories answer one cycle after the fetch strobe; off-cycle data is junk.
  always @(posedge CLK) PIX_DATA1 <= PIX_REQ1 ? 24'h800001 : 24'h000000;
  always @(posedge CLK) PIX_DATA4 <= PIX_REQ4 ? row(PIX_IDX4) : {96{1'b1}};

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int done_at, n_done, n_req, n_busy, run, tot, ones, shape_err, exp_hi;
    int req_at [0:3];
    logic [1:0] req_idx [0:3];
    logic busy_at_done;
    logic [23:0] word;
    logic [95:0] rw;

    RST1 = 1'b1; START1 = 1'b0; CH_EN1 = 1'b1;
    RST4 = 1'b1; START4 = 1'b0; CH_EN4 = 4'b0101;
    repeat (3) @(negedge CLK);
    chk("rst_led1", LED_SIG1, 0);
    chk("rst_busy1", BUSY1, 0);
    chk("rst_done1", DONE1, 0);
    chk("rst_led4", LED_SIG4, 0);
    chk("rst_req4", PIX_REQ4, 0);
    chk("rst_idx4", PIX_IDX4, 0);
    chk("rst_busy4", BUSY4, 0);
    RST1 = 1'b0; RST4 = 1'b0;
    @(negedge CLK);

    // ---- single channel, single LED, data 0x800001 ----
    START1 = 1'b1;
    done_at = -1; n_done = 0; n_req = 0; busy_at_done = 1'b1;
    for (int k = 1; k <= 4600; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        START1 = 1'b0;
        chk("f1_busy_c1", BUSY1, 1);
        chk("f1_req_c1", PIX_REQ1, 1);
      end
      tr1[k] = LED_SIG1[0];
      if (PIX_REQ1) n_req++;
      if (DONE1) begin
        n_done++;
        if (done_at < 0) begin done_at = k; busy_at_done = BUSY1; end
      end
    end
    chk("f1_done_cycle", done_at, 4515);
    chk("f1_done_count", n_done, 1);
    chk("f1_busy_at_done", busy_at_done, 0);
    chk("f1_req_count", n_req, 1);
    for (int b = 0; b < 24; b++) begin
      run = 0; tot = 0;
      while (run < 63 && tr1[3 + 63*b + run]) run++;
      for (int p = 0; p < 63; p++) tot += int'(tr1[3 + 63*b + p]);
      exp_hi = (b == 0 || b == 23) ? 40 : 20;
      chk($sformatf("f1_bit%0d_run", b), run, exp_hi);
      chk($sformatf("f1_bit%0d_total", b), tot, exp_hi);
    end
    ones = int'(tr1[1]) + int'(tr1[2]);
    for (int k = 1515; k <= 4515; k++) ones += int'(tr1[k]);
    chk("f1_quiet_outside_send", ones, 0);

    // ---- 4 channels, 3 LEDs, mask 0101 toggled mid-frame ----
    @(negedge CLK);
    START4 = 1'b1;
    done_at = -1; n_done = 0; n_req = 0;
    for (int k = 1; k <= 7543; k++) begin
      @(negedge CLK);
      if (k == 1)    START4 = 1'b0;
      if (k == 100)  CH_EN4 = 4'b1111;
      if (k == 200)  START4 = 1'b1;
      if (k == 201)  START4 = 1'b0;
      if (k == 7540) START4 = 1'b1;
      tr4[k] = LED_SIG4;
      if (PIX_REQ4) begin
        if (n_req < 4) begin req_at[n_req] = k; req_idx[n_req] = PIX_IDX4; end
        n_req++;
      end
      if (DONE4) begin n_done++; if (done_at < 0) done_at = k; end
    end
    chk("f4_done_cycle", done_at, 7543);
    chk("f4_done_count", n_done, 1);
    chk("f4_busy_at_done", BUSY4, 0);
    chk("f4_req_count", n_req, 3);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("f4_req%0d_cycle", j), req_at[j], 1 + 1514*j);
      chk($sformatf("f4_req%0d_idx", j), req_idx[j], j);
    end
    chk("f4_gap01", {tr4[1515], tr4[1516]}, 0);
    chk("f4_gap12", {tr4[3029], tr4[3030]}, 0);
    chk("f4_led1_first_high", tr4[1517][0], 1);
    ones = 0;
    for (int k = 1; k <= 7543; k++) ones += int'(tr4[k][1]) + int'(tr4[k][3]);
    chk("f4_masked_quiet", ones, 0);
    ones = 0;
    for (int k = 4543; k <= 7543; k++) ones += int'(tr4[k] != 4'd0);
    chk("f4_latch_quiet", ones, 0);
    shape_err = 0;
    for (int j = 0; j < 3; j++) begin
      rw = row(2'(j));
      for (int c = 0; c < 4; c += 2) begin
        word = '0;
        for (int b = 0; b < 24; b++) begin
          int s;
          s = 3 + 1514*j + 63*b;
          word = {word[22:0], tr4[s+20][c]};
          if (tr4[s][c] !== 1'b1 || tr4[s+19][c] !== 1'b1 || tr4[s+40][c] !== 1'b0 ||
              tr4[s+62][c] !== 1'b0 || tr4[s+39][c] !== tr4[s+20][c]) shape_err++;
        end
        chk($sformatf("f4_led%0d_ch%0d_data", j, c), word, rw[c*24 +: 24]);
      end
    end
    chk("f4_pulse_shape", shape_err, 0);

    // START held through DONE: next frame must follow at once.
    @(negedge CLK);
    START4 = 1'b0;
    chk("fB_busy_c1", BUSY4, 1);
    chk("fB_req_c1", PIX_REQ4, 1);
    chk("fB_idx_c1", PIX_IDX4, 0);

    // Run to LED 1, bit 2 start (all four lines high), then reset asynchronously.
    repeat (1642) @(negedge CLK);
    chk("fB_pre_rst_led", LED_SIG4, 4'hF);
    chk("fB_pre_rst_idx", PIX_IDX4, 1);
    #2 RST4 = 1'b1;
    #1;
    chk("arst_led", LED_SIG4, 0);
    chk("arst_busy", BUSY4, 0);
    chk("arst_req", PIX_REQ4, 0);
    chk("arst_idx", PIX_IDX4, 0);
    chk("arst_done", DONE4, 0);
    @(negedge CLK);
    RST4 = 1'b0;
    n_done = 0; n_busy = 0;
    for (int k = 0; k < 7600; k++) begin
      @(negedge CLK);
      if (DONE4) n_done++;
      if (BUSY4) n_busy++;
    end
    chk("post_rst_no_done", n_done, 0);
    chk("post_rst_idle", n_busy, 0);

    START4 = 1'b1;
    @(negedge CLK);
    START4 = 1'b0;
    chk("restart_busy", BUSY4, 1);
    chk("restart_req", PIX_REQ4, 1);
    chk("restart_idx", PIX_IDX4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
